// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit for a small accumulator CPU.
// Sequences fetch (F0..F2), decode (DEC) and execute (E0..E2). It waits on
// mem_ack during every memory access.
//
// Ports
//   CLK, RST         clock (posedge) and asynchronous active-high reset
//   run              start/continue request, sampled in IDLE and at end of instruction
//   instr            opcode field of the instruction register, valid from DEC onward
//   acc_n, acc_z     accumulator sign / zero flags used by JN / JZ
//   mem_ack          memory finished the pending read or write this cycle
//   pc_aout, pc_in, pc_inc           program counter strobes
//   ar_in                            address register load from Abus
//   ir_din, ir_aout                  instruction register strobes
//   mem_rd, mem_wr                   memory requests, held until mem_ack
//   dr_load, dr_dout, dr_din         data register strobes
//   acc_dout, acc_load, alu_op       accumulator/ALU strobes (00 pass, 01 add, 10 sub)
//   halted                           FSM is in HALT
//   illegal                          sticky flag: an opcode above 7 was decoded

module control_sequencer #(
    parameter int unsigned WORD_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 5
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                run,
    input  logic [WORD_WIDTH-ADDRESS_WIDTH-1:0] instr,
    input  logic                                acc_n,
    input  logic                                acc_z,
    input  logic                                mem_ack,
    output logic                                pc_aout,
    output logic                                pc_in,
    output logic                                pc_inc,
    output logic                                ar_in,
    output logic                                ir_din,
    output logic                                ir_aout,
    output logic                                mem_rd,
    output logic                                mem_wr,
    output logic                                dr_load,
    output logic                                dr_dout,
    output logic                                dr_din,
    output logic                                acc_dout,
    output logic                                acc_load,
    output logic [1:0]                          alu_op,
    output logic                                halted,
    output logic                                illegal
);

    localparam int unsigned OPW = WORD_WIDTH - ADDRESS_WIDTH;

    localparam logic [2:0] OP_STP   = 3'd0;
    localparam logic [2:0] OP_ADD   = 3'd1;
    localparam logic [2:0] OP_SUB   = 3'd2;
    localparam logic [2:0] OP_STORE = 3'd4;
    localparam logic [2:0] OP_JMP   = 3'd5;
    localparam logic [2:0] OP_JN    = 3'd6;
    localparam logic [2:0] OP_JZ    = 3'd7;

    typedef enum logic [3:0] {
        S_IDLE, S_F0, S_F1, S_F2, S_DEC, S_E0, S_E1, S_E2, S_HALT
    } state_t;

    state_t     state, state_nx;
    logic [2:0] op_q, op_nx;
    logic       op_bad;
    state_t     end_state;

    logic pc_aout_nx, pc_in_nx, pc_inc_nx, ar_in_nx, ir_din_nx, ir_aout_nx;
    logic mem_rd_nx, mem_wr_nx, dr_dout_nx, dr_din_nx, acc_dout_nx, acc_load_nx;
    logic [1:0] alu_op_nx;
    logic halted_nx, illegal_nx;

    // Opcodes wider than 3 bits decode above 7 as illegal STP.
    assign op_bad    = 32'(instr) > 32'd7;
    assign end_state = run ? S_F0 : S_IDLE;

    // Next state; the opcode is captured at DEC so the E states keep it.
    always_comb begin
        state_nx = state;
        op_nx    = op_q;
        case (state)
            S_IDLE: if (run) state_nx = S_F0;
            S_F0:   state_nx = S_F1;
            S_F1:   if (mem_ack) state_nx = S_F2;
            S_F2:   state_nx = S_DEC;
            S_DEC: begin
                op_nx = instr[2:0];
                if (op_bad || instr[2:0] == OP_STP)
                    state_nx = S_HALT;
                else if ((instr[2:0] == OP_JN && !acc_n) || (instr[2:0] == OP_JZ && !acc_z))
                    state_nx = end_state;
                else
                    state_nx = S_E0;
            end
            S_E0:   state_nx = (op_q >= OP_JMP) ? end_state : S_E1;
            S_E1:   if (op_q == OP_STORE || mem_ack) state_nx = S_E2;
            S_E2:   if (op_q != OP_STORE || mem_ack) state_nx = end_state;
            S_HALT: state_nx = S_HALT;
            default: state_nx = S_IDLE;
        endcase
    end

    // Strobes for the state being entered, so the registered outputs track the state.
    always_comb begin
        pc_aout_nx  = 1'b0;
        pc_in_nx    = 1'b0;
        pc_inc_nx   = 1'b0;
        ar_in_nx    = 1'b0;
        ir_din_nx   = 1'b0;
        ir_aout_nx  = 1'b0;
        mem_rd_nx   = 1'b0;
        mem_wr_nx   = 1'b0;
        dr_dout_nx  = 1'b0;
        dr_din_nx   = 1'b0;
        acc_dout_nx = 1'b0;
        acc_load_nx = 1'b0;
        alu_op_nx   = 2'b00;
        halted_nx   = 1'b0;
        illegal_nx  = illegal | (state == S_DEC && op_bad);
        case (state_nx)
            S_F0: begin
                pc_aout_nx = 1'b1;
                ar_in_nx   = 1'b1;
            end
            S_F1: mem_rd_nx = 1'b1;
            S_F2: begin
                dr_dout_nx = 1'b1;
                ir_din_nx  = 1'b1;
                pc_inc_nx  = 1'b1;
            end
            S_E0: begin
                ir_aout_nx = 1'b1;
                if (op_nx >= OP_JMP) pc_in_nx = 1'b1;
                else                 ar_in_nx = 1'b1;
            end
            S_E1: begin
                if (op_nx == OP_STORE) begin
                    acc_dout_nx = 1'b1;
                    dr_din_nx   = 1'b1;
                end else begin
                    mem_rd_nx = 1'b1;
                end
            end
            S_E2: begin
                if (op_nx == OP_STORE) begin
                    mem_wr_nx = 1'b1;
                end else begin
                    dr_dout_nx  = 1'b1;
                    acc_load_nx = 1'b1;
                    if (op_nx == OP_ADD)      alu_op_nx = 2'b01;
                    else if (op_nx == OP_SUB) alu_op_nx = 2'b10;
                end
            end
            S_HALT: halted_nx = 1'b1;
            default: ;
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            op_q     <= 3'd0;
            pc_aout  <= 1'b0;
            pc_in    <= 1'b0;
            pc_inc   <= 1'b0;
            ar_in    <= 1'b0;
            ir_din   <= 1'b0;
            ir_aout  <= 1'b0;
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            dr_dout  <= 1'b0;
            dr_din   <= 1'b0;
            acc_dout <= 1'b0;
            acc_load <= 1'b0;
            alu_op   <= 2'b00;
            halted   <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            state    <= state_nx;
            op_q     <= op_nx;
            pc_aout  <= pc_aout_nx;
            pc_in    <= pc_in_nx;
            pc_inc   <= pc_inc_nx;
            ar_in    <= ar_in_nx;
            ir_din   <= ir_din_nx;
            ir_aout  <= ir_aout_nx;
            mem_rd   <= mem_rd_nx;
            mem_wr   <= mem_wr_nx;
            dr_dout  <= dr_dout_nx;
            dr_din   <= dr_din_nx;
            acc_dout <= acc_dout_nx;
            acc_load <= acc_load_nx;
            alu_op   <= alu_op_nx;
            halted   <= halted_nx;
            illegal  <= illegal_nx;
        end
    end

    // mem_rd is high exactly in F1 and in E1 of a read, so DR captures on the acked cycle.
    assign dr_load = mem_rd & mem_ack;

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer (OPW = 4). Each instruction is expanded into
// its expected per-cycle strobe pattern, queued, and checked by a monitor.

module tb_control_sequencer;

    logic CLK = 1'b0;
    logic RST, run, acc_n, acc_z, mem_ack;
    logic [3:0] instr;
    logic pc_aout, pc_in, pc_inc, ar_in, ir_din, ir_aout, mem_rd, mem_wr;
    logic dr_load, dr_dout, dr_din, acc_dout, acc_load, halted, illegal;
    logic [1:0] alu_op;

    always #5 CLK = ~CLK;

    control_sequencer #(.WORD_WIDTH(9), .ADDRESS_WIDTH(5)) dut (
        .CLK(CLK), .RST(RST), .run(run), .instr(instr), .acc_n(acc_n), .acc_z(acc_z),
        .mem_ack(mem_ack), .pc_aout(pc_aout), .pc_in(pc_in), .pc_inc(pc_inc),
        .ar_in(ar_in), .ir_din(ir_din), .ir_aout(ir_aout), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .dr_load(dr_load), .dr_dout(dr_dout), .dr_din(dr_din),
        .acc_dout(acc_dout), .acc_load(acc_load), .alu_op(alu_op),
        .halted(halted), .illegal(illegal)
    );

    localparam logic [16:0] B_PC_AOUT  = 17'h10000;
    localparam logic [16:0] B_PC_IN    = 17'h08000;
    localparam logic [16:0] B_PC_INC   = 17'h04000;
    localparam logic [16:0] B_AR_IN    = 17'h02000;
    localparam logic [16:0] B_IR_DIN   = 17'h01000;
    localparam logic [16:0] B_IR_AOUT  = 17'h00800;
    localparam logic [16:0] B_MEM_RD   = 17'h00400;
    localparam logic [16:0] B_MEM_WR   = 17'h00200;
    localparam logic [16:0] B_DR_LOAD  = 17'h00100;
    localparam logic [16:0] B_DR_DOUT  = 17'h00080;
    localparam logic [16:0] B_DR_DIN   = 17'h00040;
    localparam logic [16:0] B_ACC_DOUT = 17'h00020;
    localparam logic [16:0] B_ACC_LOAD = 17'h00010;
    localparam logic [16:0] B_SUB      = 17'h00008;
    localparam logic [16:0] B_ADD      = 17'h00004;
    localparam logic [16:0] B_HALTED   = 17'h00002;
    localparam logic [16:0] B_ILL      = 17'h00001;

    logic [16:0] dut_vec;
    assign dut_vec = {pc_aout, pc_in, pc_inc, ar_in, ir_din, ir_aout, mem_rd, mem_wr,
                      dr_load, dr_dout, dr_din, acc_dout, acc_load, alu_op, halted, illegal};

    logic [16:0] exp_q[$];
    logic [16:0] mon_e;
    logic        ill;
    int checks   = 0;
    int failures = 0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock cycle: drive inputs for it and queue the outputs it must show.
    task automatic cyc(input logic [16:0] e, input logic ack, input logic r);
        mem_ack = ack;
        run     = r;
        exp_q.push_back(e | (ill ? B_ILL : 17'h0));
        @(posedge CLK);
        #1;
    endtask

    // Expand one instruction into its cycle pattern. wf/we: ack wait cycles in
    // fetch/execute memory access; rend: run value at the end of the instruction.
    task automatic do_instr(input logic [3:0] op, input logic n, input logic z,
                            input int wf, input int we, input logic rend);
        logic [16:0] alu;
        logic        taken;
        acc_n = n;
        acc_z = z;
        instr = 4'($urandom_range(0, 15));
        cyc(B_PC_AOUT | B_AR_IN, rb(), rb());
        repeat (wf) cyc(B_MEM_RD, 1'b0, rb());
        cyc(B_MEM_RD | B_DR_LOAD, 1'b1, rb());
        cyc(B_DR_DOUT | B_IR_DIN | B_PC_INC, rb(), rb());
        instr = op;
        if (op == 4'd0 || op > 4'd7) begin
            cyc(17'h0, rb(), rb());
            if (op > 4'd7) ill = 1'b1;
            return;
        end
        taken = (op == 4'd5) || (op == 4'd6 && n) || (op == 4'd7 && z);
        if (op >= 4'd6 && !taken) begin
            cyc(17'h0, rb(), rend);
        end else begin
            cyc(17'h0, rb(), rb());
            if (op >= 4'd5) begin
                cyc(B_IR_AOUT | B_PC_IN, rb(), rend);
            end else if (op == 4'd4) begin
                cyc(B_IR_AOUT | B_AR_IN, rb(), rb());
                cyc(B_ACC_DOUT | B_DR_DIN, rb(), rb());
                repeat (we) cyc(B_MEM_WR, 1'b0, rb());
                cyc(B_MEM_WR, 1'b1, rend);
            end else begin
                alu = (op == 4'd1) ? B_ADD : (op == 4'd2) ? B_SUB : 17'h0;
                cyc(B_IR_AOUT | B_AR_IN, rb(), rb());
                repeat (we) cyc(B_MEM_RD, 1'b0, rb());
                cyc(B_MEM_RD | B_DR_LOAD, 1'b1, rb());
                cyc(B_DR_DOUT | B_ACC_LOAD | alu, rb(), rend);
            end
        end
        if (!rend) begin
            repeat (int'($urandom_range(1, 3))) cyc(17'h0, rb(), 1'b0);
            cyc(17'h0, rb(), 1'b1);
        end
    endtask

    // Monitor: compare every cycle against the queued expectation.
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (dut_vec !== mon_e) begin
                failures++;
                $display("FAIL strobes t=%0t got=%05h exp=%05h", $time, dut_vec, mon_e);
            end
            checks++;
            if ((pc_aout && ir_aout) || (dr_dout && acc_dout)) begin
                failures++;
                $display("FAIL bus_conflict t=%0t got abus=%b%b dbus=%b%b exp at most one driver each",
                         $time, pc_aout, ir_aout, dr_dout, acc_dout);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] op;
        int wf, we;
        RST = 1'b1; run = 1'b0; acc_n = 1'b0; acc_z = 1'b0; mem_ack = 1'b0;
        instr = 4'd0; ill = 1'b0;
        @(posedge CLK);
        #1;
        repeat (2) cyc(17'h0, rb(), rb());
        RST = 1'b0;
        cyc(17'h0, rb(), 1'b0);
        cyc(17'h0, rb(), 1'b1);

        // Directed: LOAD, untaken/taken JN, STORE with slow ack, JZ then idle.
        do_instr(4'd3, 1'b0, 1'b0, 0, 0, 1'b1);
        do_instr(4'd6, 1'b0, 1'b0, 0, 0, 1'b1);
        do_instr(4'd6, 1'b1, 1'b0, 0, 0, 1'b1);
        do_instr(4'd4, 1'b0, 1'b0, 0, 3, 1'b1);
        do_instr(4'd7, 1'b0, 1'b1, 1, 0, 1'b0);
        do_instr(4'd7, 1'b1, 1'b0, 0, 0, 1'b1);

        // Random instruction stream.
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(1, 7));
            wf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            we = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            do_instr(op, rb(), rb(), wf, we, $urandom_range(0, 4) != 0);
        end

        // Reset while waiting in F1.
        cyc(B_PC_AOUT | B_AR_IN, rb(), rb());
        cyc(B_MEM_RD, 1'b0, rb());
        RST = 1'b1;
        cyc(17'h0, 1'b0, rb());
        RST = 1'b0;
        cyc(17'h0, rb(), 1'b1);

        // STP halts until reset.
        do_instr(4'd0, rb(), rb(), 0, 0, 1'b1);
        repeat (20) cyc(B_HALTED, rb(), 1'b1);
        RST = 1'b1;
        cyc(17'h0, rb(), 1'b1);
        RST = 1'b0;
        cyc(17'h0, rb(), 1'b1);

        // Illegal opcode: halts and sets sticky illegal.
        do_instr(4'(8 + $urandom_range(0, 7)), rb(), rb(), 1, 0, 1'b1);
        repeat (5) cyc(B_HALTED, rb(), 1'b1);
        RST = 1'b1;
        ill = 1'b0;
        cyc(17'h0, rb(), 1'b1);
        RST = 1'b0;
        repeat (3) cyc(17'h0, rb(), 1'b0);

        @(negedge CLK);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
